// File: rtl/ref_fetch_pkg.sv
// Shared constants and FSM encoding for the reference search-window fetch block.
package ref_fetch_pkg;

    localparam int LANES      = 16;
    localparam int ROW_STRIDE = 16;
    localparam int ADDR_W     = 13;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_A,
        ISSUE_B,
        CAPT_A,
        CAPT_B,
        OUT
    } state_t;

endpackage

// File: rtl/ref_row_align.sv
// Purpose: pick BLK_W pixels starting at lane pos (leftmost = high lane), spilling into word B.
// Latency: combinational.
// Backpressure: none; the caller registers the result.
module ref_row_align #(
    parameter int BD    = 8,
    parameter int BLK_W = 4,
    parameter int LANES = ref_fetch_pkg::LANES
) (
    input  logic [LANES*BD-1:0] word_a,
    input  logic [LANES*BD-1:0] word_b,
    input  logic [3:0]          pos,
    input  logic                replicate,
    output logic [BLK_W*BD-1:0] row
);

    int p;

    always_comb begin
        row = '0;
        p   = int'(pos);
        for (int k = 0; k < BLK_W; k++) begin
            if (p >= k) begin
                row[k*BD +: BD] = word_a[(p - k)*BD +: BD];
            end else if (replicate) begin
                // Right edge of the window: smear the last real pixel.
                row[k*BD +: BD] = word_a[BD-1:0];
            end else begin
                row[k*BD +: BD] = word_b[(LANES + p - k)*BD +: BD];
            end
        end
    end

endmodule

// File: rtl/ref_win_fetch.sv
// Purpose: fetch a BLK_W x BLK_H reference block from the search-window SRAM, one aligned row at a time.
// Latency: first row 3 cycles after the request handshake (4 when a second word is read), same per later row.
// Backpressure: a row is held stable in OUT until row_ready; no SRAM reads and no new requests meanwhile.
module ref_win_fetch #(
    parameter int BD         = 8,
    parameter int BLK_W      = 4,
    parameter int BLK_H      = 4,
    parameter int LANES      = ref_fetch_pkg::LANES,
    parameter int ROW_STRIDE = ref_fetch_pkg::ROW_STRIDE
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [ref_fetch_pkg::ADDR_W-1:0]  req_addr,
    input  logic [3:0]                        req_pos,
    output logic                              mem_rd_en,
    output logic [ref_fetch_pkg::ADDR_W-1:0]  mem_addr,
    input  logic [LANES*BD-1:0]               mem_rd_data,
    output logic                              row_valid,
    input  logic                              row_ready,
    output logic [BLK_W*BD-1:0]               row_data,
    output logic [3:0]                        row_idx,
    output logic                              row_last,
    output logic                              busy
);

    import ref_fetch_pkg::*;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   row_base_q;
    logic [3:0]          pos_q;
    logic                rd_b_q;
    logic [3:0]          r_q;
    logic                row_last_q;
    logic [LANES*BD-1:0] word_a_q;
    logic [BLK_W*BD-1:0] row_data_q;

    logic                need_b;
    logic                at_edge;
    logic [LANES*BD-1:0] align_a;
    logic [BLK_W*BD-1:0] aligned;

    assign need_b  = (5'(req_pos) + 5'd1) < 5'(BLK_W);
    // Last word of a window row: the spill word would belong to the next row, so never read it.
    assign at_edge = (req_addr[3:0] == 4'hF);

    assign align_a = (state_q == CAPT_B) ? word_a_q : mem_rd_data;

    ref_row_align #(
        .BD    (BD),
        .BLK_W (BLK_W),
        .LANES (LANES)
    ) u_align (
        .word_a    (align_a),
        .word_b    (mem_rd_data),
        .pos       (pos_q),
        .replicate (state_q == CAPT_A),
        .row       (aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) state_d = ISSUE_A;
            end
            ISSUE_A: begin
                mem_rd_en = 1'b1;
                mem_addr  = row_base_q;
                state_d   = rd_b_q ? ISSUE_B : CAPT_A;
            end
            ISSUE_B: begin
                mem_rd_en = 1'b1;
                mem_addr  = row_base_q + ADDR_W'(1);
                state_d   = CAPT_B;
            end
            CAPT_A, CAPT_B: begin
                state_d = OUT;
            end
            OUT: begin
                if (row_ready) state_d = row_last_q ? IDLE : ISSUE_A;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_base_q <= '0;
            pos_q      <= '0;
            rd_b_q     <= 1'b0;
            r_q        <= '0;
            row_last_q <= 1'b0;
            word_a_q   <= '0;
            row_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        row_base_q <= req_addr;
                        pos_q      <= req_pos;
                        rd_b_q     <= need_b && !at_edge;
                        r_q        <= '0;
                        row_last_q <= 1'b0;
                    end
                end
                ISSUE_B: begin
                    word_a_q <= mem_rd_data;
                end
                CAPT_A, CAPT_B: begin
                    if (state_q == CAPT_A) word_a_q <= mem_rd_data;
                    row_data_q <= aligned;
                    row_last_q <= (r_q == 4'(BLK_H - 1));
                end
                OUT: begin
                    if (row_ready && !row_last_q) begin
                        r_q        <= r_q + 4'd1;
                        row_base_q <= row_base_q + ADDR_W'(ROW_STRIDE);
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign row_valid = (state_q == OUT);
    assign row_data  = row_data_q;
    assign row_idx   = r_q;
    assign row_last  = row_last_q;

endmodule

// File: tb/tb_ref_win_fetch.sv
// Scoreboard bench for ref_win_fetch: a reference model queues expected reads and rows, a monitor compares.
module tb_ref_win_fetch;

    localparam int BD    = 8;
    localparam int BLK_W = 4;
    localparam int BLK_H = 4;
    localparam int LANES = 16;
    localparam int RW    = BLK_W * BD;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                req_valid;
    logic                req_ready;
    logic [12:0]         req_addr;
    logic [3:0]          req_pos;
    logic                mem_rd_en;
    logic [12:0]         mem_addr;
    logic [LANES*BD-1:0] mem_rd_data = '0;
    logic                row_valid;
    logic                row_ready;
    logic [RW-1:0]       row_data;
    logic [3:0]          row_idx;
    logic                row_last;
    logic                busy;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int rdy_mode   = 0;

    typedef struct {
        logic [RW-1:0] data;
        int            idx;
        bit            last;
    } row_t;

    row_t          exp_rows[$];
    int            exp_rd[$];
    int            acc_cyc[$];
    row_t          mon_e;
    logic [RW-1:0] held_data;
    logic [3:0]    held_idx;
    bit            holding = 0;

    ref_win_fetch #(.BD(BD), .BLK_W(BLK_W), .BLK_H(BLK_H)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_pos     (req_pos),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .row_data    (row_data),
        .row_idx     (row_idx),
        .row_last    (row_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pix(int w, int l);
        return 8'(w + l);
    endfunction

    // SRAM: one-cycle read latency; junk on cycles without a read so stale captures show up.
    always @(posedge clk) begin
        for (int l = 0; l < LANES; l++)
            mem_rd_data[l*BD +: BD] <= mem_rd_en ? pix(int'(mem_addr), l) : 8'($urandom);
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: pixel k of row r sits k columns right of the top-left pixel; columns to the
    // right of lane 0 continue in the next word, unless that word lies outside the window row.
    task automatic push_expect(int addr, int pos);
        bit            rd_b;
        int            rb;
        int            g;
        logic [RW-1:0] d;
        row_t          e;
        rd_b = (pos + 1 < BLK_W) && ((addr % 16) != 15);
        for (int r = 0; r < BLK_H; r++) begin
            rb = (addr + r * 16) % 8192;
            exp_rd.push_back(rb);
            if (rd_b) exp_rd.push_back((rb + 1) % 8192);
            d = '0;
            for (int k = 0; k < BLK_W; k++) begin
                g = pos - k;
                if (g >= 0)    d[k*BD +: BD] = pix(rb, g);
                else if (rd_b) d[k*BD +: BD] = pix((rb + 1) % 8192, LANES + g);
                else           d[k*BD +: BD] = pix(rb, 0);
            end
            e.data = d;
            e.idx  = r;
            e.last = (r == BLK_H - 1);
            exp_rows.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en) begin
                if (exp_rd.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL spurious_read: addr 0x%0h with none expected (cycle %0d)", mem_addr, cyc);
                end else begin
                    check("rd_addr", 64'(mem_addr), 64'(exp_rd.pop_front()));
                end
            end
            if (row_valid) begin
                if (holding) begin
                    check("hold_data", 64'(row_data), 64'(held_data));
                    check("hold_idx", 64'(row_idx), 64'(held_idx));
                end
                if (exp_rows.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL spurious_row: idx %0d data 0x%0h with none expected", row_idx, row_data);
                    holding = 0;
                end else if (row_ready) begin
                    mon_e = exp_rows.pop_front();
                    check("row_data", 64'(row_data), 64'(mon_e.data));
                    check("row_idx", 64'(row_idx), 64'(mon_e.idx));
                    check("row_last", 64'(row_last), 64'(mon_e.last));
                    acc_cyc.push_back(cyc);
                    holding = 0;
                end else begin
                    holding   = 1;
                    held_data = row_data;
                    held_idx  = row_idx;
                end
            end else begin
                holding = 0;
            end
        end else begin
            holding = 0;
        end
    end

    initial begin
        row_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0)      row_ready = 1'b1;
            else if (rdy_mode == 1) row_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic issue_req(int addr, int pos, output int hs_cyc);
        int n;
        bit ok;
        n      = 0;
        ok     = 0;
        hs_cyc = 0;
        push_expect(addr, pos);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_addr  = 13'(addr);
        req_pos   = 4'(pos);
        while (!ok && n < 200) begin
            @(negedge clk);
            ok     = req_ready;
            hs_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = 1'b0;
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL req_handshake: req_ready stayed 0 for %0d cycles", n);
        end
    endtask

    task automatic check_latency(int hs_cyc, int exp_lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!row_valid && n < 50);
        check("first_row_latency", 64'(cyc - hs_cyc), 64'(exp_lat));
    endtask

    task automatic wait_done(string tag);
        int n;
        n = 0;
        while ((exp_rows.size() != 0 || exp_rd.size() != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: %0d rows and %0d reads outstanding", tag, exp_rows.size(), exp_rd.size());
            exp_rows.delete();
            exp_rd.delete();
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({tag, "_idle_req_ready"}, 64'(req_ready), 64'(1));
        check({tag, "_idle_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int hs;
        int n;
        int a;
        int p;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_pos   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_row_valid", 64'(row_valid), 64'(0));
        check("rst_row_data", 64'(row_data), 64'(0));
        check("rst_row_idx", 64'(row_idx), 64'(0));
        check("rst_row_last", 64'(row_last), 64'(0));
        check("rst_mem_rd_en", 64'(mem_rd_en), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        rst_n = 1'b1;

        // Aligned block: single read per row, rows 3 cycles apart
        acc_cyc.delete();
        issue_req('h010, 15, hs);
        check_latency(hs, 3);
        wait_done("aligned");
        check("aligned_row_count", 64'(acc_cyc.size()), 64'(BLK_H));
        for (int i = 1; i < acc_cyc.size(); i++)
            check("aligned_row_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(3));

        // Spill into the next word
        issue_req('h010, 1, hs);
        check_latency(hs, 4);
        wait_done("spill");

        // Right window edge: replicate instead of reading the next word
        issue_req('h01F, 1, hs);
        check_latency(hs, 3);
        wait_done("edge");

        // 13-bit address wrap
        issue_req('h1FF0, 15, hs);
        wait_done("wrap");

        // Backpressure during row 1
        rdy_mode  = 2;
        row_ready = 1'b1;
        issue_req('h200, 2, hs);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(row_valid && row_idx == 4'd0) && n < 50);
        @(posedge clk);
        #1;
        row_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!row_valid && n < 50);
        for (int i = 0; i < 5; i++) begin
            check("bp_row_valid", 64'(row_valid), 64'(1));
            check("bp_row_idx", 64'(row_idx), 64'(1));
            check("bp_mem_rd_en", 64'(mem_rd_en), 64'(0));
            check("bp_req_ready", 64'(req_ready), 64'(0));
            @(posedge clk);
            #1;
            req_valid = 1'b1;
            req_addr  = 13'($urandom);
            req_pos   = 4'($urandom);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rdy_mode  = 0;
        row_ready = 1'b1;
        wait_done("backpressure");

        // Reset while reading word B of row 2
        issue_req('h010, 1, hs);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_rd_en && mem_addr == 13'h031) && n < 100);
        check("mid_rst_reached_row2_b", 64'(mem_addr), 64'('h031));
        rst_n = 1'b0;
        #1;
        check("mid_rst_row_valid", 64'(row_valid), 64'(0));
        check("mid_rst_row_data", 64'(row_data), 64'(0));
        check("mid_rst_row_idx", 64'(row_idx), 64'(0));
        check("mid_rst_row_last", 64'(row_last), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_mem_rd_en", 64'(mem_rd_en), 64'(0));
        check("mid_rst_mem_addr", 64'(mem_addr), 64'(0));
        check("mid_rst_req_ready", 64'(req_ready), 64'(1));
        exp_rows.delete();
        exp_rd.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        issue_req('h100, 15, hs);
        check_latency(hs, 3);
        wait_done("post_reset");

        // Randomized requests with random downstream stalls
        rdy_mode = 1;
        for (int i = 0; i < 24; i++) begin
            a = int'($urandom_range(0, 8191));
            p = int'($urandom_range(0, 15));
            issue_req(a, p, hs);
            check_latency(hs, ((p + 1 < BLK_W) && ((a % 16) != 15)) ? 4 : 3);
            wait_done("random");
        end
        rdy_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ref_win_fetch.md
Name: ref_win_fetch

Overview:
- Read-side responder for the affine MC reference search window. Accepts a (word address, lane position) request from the address calculator for a 4x4 reference sub-block.
- Reads the 16-pixel-per-word search-window SRAM, two words per row where the block straddles a word boundary. Emits the reference block row by row, pixel-aligned, to the interpolation stage under valid/ready backpressure.

Parameters:
- BD, 8, pixel bit depth.
- BLK_W, 4, pixels per output row (legal 1..16).
- BLK_H, 4, rows per request (legal 1..16).
- LANES, 16, pixels per SRAM word (fixed).
- ROW_STRIDE, 16, SRAM words per search-window row.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  high only in IDLE.
- req_addr  in  13  word address of the word holding the top-left pixel.
- req_pos  in  4  lane of the top-left pixel. Lane 15 is the leftmost pixel in a word.
- mem_rd_en  out  1  SRAM read strobe. Read data is returned 1 cycle later.
- mem_addr  out  13  SRAM word address.
- mem_rd_data  in  LANES*BD  SRAM read data. Lane l occupies bits [l*BD+BD-1 : l*BD].
- row_valid  out  1  output row valid.
- row_ready  in  1  downstream accepts the row.
- row_data  out  BLK_W*BD  aligned row. Pixel k (k=0 is leftmost) occupies bits [k*BD+BD-1 : k*BD].
- row_idx  out  4  index of the current row, 0..BLK_H-1.
- row_last  out  1  high with row_idx==BLK_H-1.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE.
  - row_valid, row_data, row_idx, row_last, busy, mem_rd_en and mem_addr are all 0.
  - req_ready=1 because the FSM is in IDLE.
  - Capture registers are cleared.
  - Reset mid-request abandons the request. No row is emitted and no SRAM read is issued afterward.
- Per-request decode values:
  - base = req_addr, latched on req_valid && req_ready.
  - pos = req_pos, latched on the same handshake.
  - need_b = (pos+1 < BLK_W).
  - edge = (base[3:0] == 15).
  - rd_b = need_b && !edge.
- Row r word addresses, all arithmetic modulo 2^13 (wraps, no clamp):
  - row_base = base + r*ROW_STRIDE.
  - Word B address = row_base + 1.
- FSM states and transitions:
  - IDLE: on handshake, latch the request and set r=0, then go to ISSUE_A.
  - ISSUE_A: mem_rd_en=1, mem_addr=row_base. Go to ISSUE_B if rd_b, else to CAPT_A.
  - ISSUE_B: mem_rd_en=1, mem_addr=row_base+1. Capture mem_rd_data into word A. Go to CAPT_B.
  - CAPT_A: capture word A. Word B is treated as all lanes equal to A lane 0 (edge replicate). Go to OUT.
  - CAPT_B: capture word B. Go to OUT.
  - OUT: row_valid=1; row_data, row_idx and row_last are registered and held stable.
    - On row_ready with row_last: go to IDLE.
    - On row_ready without row_last: increment r and go to ISSUE_A.
    - Without row_ready: hold; no SRAM reads are issued.
- Alignment, computed on capture and registered into row_data:
  - pixel k = A lane (pos-k) if pos >= k.
  - Otherwise pixel k = B lane (LANES+pos-k).
- Latency:
  - First row_valid appears 3 cycles after the handshake (rd_b=0) or 4 cycles (rd_b=1).
  - Each later row follows 3 or 4 cycles after the prior row_ready.
- mem_rd_en=0 in IDLE, CAPT_A, CAPT_B and OUT.
- req_valid in non-IDLE states is ignored (not accepted).

Decomposition:
- Package ref_fetch_pkg:
  - FSM state enum: IDLE, ISSUE_A, ISSUE_B, CAPT_A, CAPT_B, OUT.
  - Constants LANES=16, ROW_STRIDE=16, ADDR_W=13.
- Sub-module ref_row_align (combinational), inputs: word A, word B, pos, replicate flag. Output: the BLK_W-pixel row.
- FSM, counters and registers stay in ref_win_fetch.

Test Plan:
- In all tests the SRAM model returns lane l of word a equal to (a+l) & 0xFF.
- Aligned block: req_addr=0x010, req_pos=15, BLK 4x4.
  - Expect reads at 0x010, 0x020, 0x030 and 0x040 only.
  - Row 0 = {0x1F, 0x1E, 0x1D, 0x1C}.
  - Rows are 3 cycles apart with row_ready tied high.
  - row_last is set on row 3 only.
- Spill: req_addr=0x010, req_pos=1.
  - Each row issues 2 reads: row_base, then row_base+1.
  - Row 0 = {0x11, 0x10, 0x20, 0x1F}.
  - First row_valid appears 4 cycles after the handshake.
- Edge replicate: req_addr=0x01F, req_pos=1.
  - No read of 0x020 during row 0.
  - Row 0 = {0x20, 0x1F, 0x1F, 0x1F}.
- Backpressure: row_ready held low 5 cycles during row 1.
  - row_data and row_idx stay stable.
  - mem_rd_en stays 0.
  - req_valid is ignored and req_ready stays 0.
- Address wrap: req_addr=0x1FF0, req_pos=15.
  - Row 1 reads address 0x0000 (13-bit wrap).
- Reset mid-operation: assert rst_n=0 during ISSUE_B of row 2.
  - All outputs are immediately 0; after reset req_ready=1.
  - A new request then completes normally with row_idx starting at 0.
